// File: rtl/decode_stage.sv
// Instruction-decode stage: decodes the ID instruction, reads the 32x32 register file,
// resolves load-use stalls and branch squash, and loads the ID/EX pipeline register.
module decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] FetchData_IF,
    input  logic [31:0] PcPlus4_ID,
    input  logic        BranchTaken_EX,
    input  logic        RegWrite_WB,
    input  logic [4:0]  WriteReg_WB,
    input  logic [31:0] WriteData_WB,
    output logic        Jump_ID,
    output logic [25:0] JumpTgt_ID,
    output logic        AnyStall,
    output logic [31:0] RegA_EX,
    output logic [31:0] RegB_EX,
    output logic [31:0] Imm_EX,
    output logic [4:0]  Rs_EX,
    output logic [4:0]  Rt_EX,
    output logic [4:0]  WriteReg_EX,
    output logic [2:0]  AluOp_EX,
    output logic        AluSrcImm_EX,
    output logic        RegWrite_EX,
    output logic        MemRead_EX,
    output logic        MemWrite_EX,
    output logic        MemToReg_EX,
    output logic        Branch_EX,
    output logic [31:0] PcPlus4_EX,
    output logic        IllegalSeen
);

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2b;

    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;
    localparam logic [5:0] FnAnd = 6'h24;
    localparam logic [5:0] FnOr  = 6'h25;
    localparam logic [5:0] FnSlt = 6'h2a;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluSlt = 3'b100;

    // valid=1 means the instruction writes real control into ID/EX (j and NOP do not).
    typedef struct packed {
        logic       valid;
        logic       illegal;
        logic       isJump;
        logic       readsRs;
        logic       readsRt;
        logic       aluSrcImm;
        logic       regWrite;
        logic       memRead;
        logic       memWrite;
        logic       memToReg;
        logic       branch;
        logic [2:0] aluOp;
        logic [4:0] writeReg;
    } ctrl_t;

    function automatic ctrl_t decodeInstr(input logic [31:0] instr);
        ctrl_t c;
        c = '0;
        case (instr[31:26])
            OpRtype: begin
                if (instr == 32'h0000_0000) begin
                    c.valid = 1'b0;
                end else begin
                    case (instr[5:0])
                        FnAdd:   begin c.aluOp = AluAdd; c.valid = 1'b1; end
                        FnSub:   begin c.aluOp = AluSub; c.valid = 1'b1; end
                        FnAnd:   begin c.aluOp = AluAnd; c.valid = 1'b1; end
                        FnOr:    begin c.aluOp = AluOr;  c.valid = 1'b1; end
                        FnSlt:   begin c.aluOp = AluSlt; c.valid = 1'b1; end
                        default: c.illegal = 1'b1;
                    endcase
                    c.readsRs  = c.valid;
                    c.readsRt  = c.valid;
                    c.regWrite = c.valid;
                    c.writeReg = c.valid ? instr[15:11] : 5'd0;
                end
            end
            OpLw: begin
                c.valid     = 1'b1;
                c.readsRs   = 1'b1;
                c.aluSrcImm = 1'b1;
                c.regWrite  = 1'b1;
                c.memRead   = 1'b1;
                c.memToReg  = 1'b1;
                c.aluOp     = AluAdd;
                c.writeReg  = instr[20:16];
            end
            OpSw: begin
                c.valid     = 1'b1;
                c.readsRs   = 1'b1;
                c.readsRt   = 1'b1;
                c.aluSrcImm = 1'b1;
                c.memWrite  = 1'b1;
                c.aluOp     = AluAdd;
            end
            OpBeq: begin
                c.valid   = 1'b1;
                c.readsRs = 1'b1;
                c.readsRt = 1'b1;
                c.branch  = 1'b1;
                c.aluOp   = AluSub;
            end
            OpAddi: begin
                c.valid     = 1'b1;
                c.readsRs   = 1'b1;
                c.aluSrcImm = 1'b1;
                c.regWrite  = 1'b1;
                c.aluOp     = AluAdd;
                c.writeReg  = instr[20:16];
            end
            OpJ: begin
                c.isJump = 1'b1;
            end
            default: c.illegal = 1'b1;
        endcase
        return c;
    endfunction

    logic [31:0] regFile_r [0:31];
    ctrl_t       dec_s;
    logic [4:0]  rsIdx_s;
    logic [4:0]  rtIdx_s;
    logic [31:0] rsVal_s;
    logic [31:0] rtVal_s;
    logic [31:0] immExt_s;
    logic        hazard_s;
    logic        loadBubble_s;

    assign dec_s      = decodeInstr(FetchData_IF);
    assign rsIdx_s    = FetchData_IF[25:21];
    assign rtIdx_s    = FetchData_IF[20:16];
    assign immExt_s   = {{16{FetchData_IF[15]}}, FetchData_IF[15:0]};
    assign JumpTgt_ID = FetchData_IF[25:0];

    // Register-file read; a same-cycle WB write is bypassed, $0 always reads zero.
    always_comb begin
        if (rsIdx_s == 5'd0) begin
            rsVal_s = 32'h0000_0000;
        end else if (RegWrite_WB && (WriteReg_WB == rsIdx_s)) begin
            rsVal_s = WriteData_WB;
        end else begin
            rsVal_s = regFile_r[rsIdx_s];
        end
        if (rtIdx_s == 5'd0) begin
            rtVal_s = 32'h0000_0000;
        end else if (RegWrite_WB && (WriteReg_WB == rtIdx_s)) begin
            rtVal_s = WriteData_WB;
        end else begin
            rtVal_s = regFile_r[rtIdx_s];
        end
    end

    // Load-use detection against sources the ID instruction really reads.
    always_comb begin
        hazard_s = 1'b0;
        if (MemRead_EX && (WriteReg_EX != 5'd0)) begin
            hazard_s = (dec_s.readsRs && (rsIdx_s == WriteReg_EX)) ||
                       (dec_s.readsRt && (rtIdx_s == WriteReg_EX));
        end else begin
            hazard_s = 1'b0;
        end
    end

    // Fetch-facing controls; a squashed or reset cycle must show neither jump nor stall.
    always_comb begin
        Jump_ID  = 1'b0;
        AnyStall = 1'b0;
        if (reset || BranchTaken_EX) begin
            Jump_ID  = 1'b0;
            AnyStall = 1'b0;
        end else begin
            Jump_ID  = dec_s.isJump;
            AnyStall = hazard_s;
        end
        loadBubble_s = reset || BranchTaken_EX || hazard_s || !dec_s.valid;
    end

    // ID/EX pipeline register.
    always_ff @(posedge clk) begin
        if (loadBubble_s) begin
            RegA_EX      <= 32'h0000_0000;
            RegB_EX      <= 32'h0000_0000;
            Imm_EX       <= 32'h0000_0000;
            Rs_EX        <= 5'd0;
            Rt_EX        <= 5'd0;
            WriteReg_EX  <= 5'd0;
            AluOp_EX     <= 3'b000;
            AluSrcImm_EX <= 1'b0;
            RegWrite_EX  <= 1'b0;
            MemRead_EX   <= 1'b0;
            MemWrite_EX  <= 1'b0;
            MemToReg_EX  <= 1'b0;
            Branch_EX    <= 1'b0;
            PcPlus4_EX   <= 32'h0000_0000;
        end else begin
            RegA_EX      <= rsVal_s;
            RegB_EX      <= rtVal_s;
            Imm_EX       <= immExt_s;
            Rs_EX        <= rsIdx_s;
            Rt_EX        <= rtIdx_s;
            WriteReg_EX  <= dec_s.writeReg;
            AluOp_EX     <= dec_s.aluOp;
            AluSrcImm_EX <= dec_s.aluSrcImm;
            RegWrite_EX  <= dec_s.regWrite;
            MemRead_EX   <= dec_s.memRead;
            MemWrite_EX  <= dec_s.memWrite;
            MemToReg_EX  <= dec_s.memToReg;
            Branch_EX    <= dec_s.branch;
            PcPlus4_EX   <= PcPlus4_ID;
        end
    end

    // Register-file write port; $0 is never written.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regFile_r[i] <= 32'h0000_0000;
            end
        end else if (RegWrite_WB && (WriteReg_WB != 5'd0)) begin
            regFile_r[WriteReg_WB] <= WriteData_WB;
        end else begin
            regFile_r[WriteReg_WB] <= regFile_r[WriteReg_WB];
        end
    end

    // Sticky illegal-instruction flag; wrong-path instructions do not count.
    always_ff @(posedge clk) begin
        if (reset) begin
            IllegalSeen <= 1'b0;
        end else if (!BranchTaken_EX && dec_s.illegal) begin
            IllegalSeen <= 1'b1;
        end else begin
            IllegalSeen <= IllegalSeen;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: scoreboard of expected ID/EX contents
// plus same-cycle checks of the fetch-facing controls.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] FetchData_IF = 32'h0;
    logic [31:0] PcPlus4_ID = 32'h0;
    logic        BranchTaken_EX = 1'b0;
    logic        RegWrite_WB = 1'b0;
    logic [4:0]  WriteReg_WB = 5'd0;
    logic [31:0] WriteData_WB = 32'h0;
    logic        Jump_ID;
    logic [25:0] JumpTgt_ID;
    logic        AnyStall;
    logic [31:0] RegA_EX, RegB_EX, Imm_EX, PcPlus4_EX;
    logic [4:0]  Rs_EX, Rt_EX, WriteReg_EX;
    logic [2:0]  AluOp_EX;
    logic        AluSrcImm_EX, RegWrite_EX, MemRead_EX, MemWrite_EX, MemToReg_EX, Branch_EX;
    logic        IllegalSeen;

    decode_stage dut (
        .clk(clk), .reset(reset), .FetchData_IF(FetchData_IF), .PcPlus4_ID(PcPlus4_ID),
        .BranchTaken_EX(BranchTaken_EX), .RegWrite_WB(RegWrite_WB), .WriteReg_WB(WriteReg_WB),
        .WriteData_WB(WriteData_WB), .Jump_ID(Jump_ID), .JumpTgt_ID(JumpTgt_ID),
        .AnyStall(AnyStall), .RegA_EX(RegA_EX), .RegB_EX(RegB_EX), .Imm_EX(Imm_EX),
        .Rs_EX(Rs_EX), .Rt_EX(Rt_EX), .WriteReg_EX(WriteReg_EX), .AluOp_EX(AluOp_EX),
        .AluSrcImm_EX(AluSrcImm_EX), .RegWrite_EX(RegWrite_EX), .MemRead_EX(MemRead_EX),
        .MemWrite_EX(MemWrite_EX), .MemToReg_EX(MemToReg_EX), .Branch_EX(Branch_EX),
        .PcPlus4_EX(PcPlus4_EX), .IllegalSeen(IllegalSeen)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] regA;
        logic [31:0] regB;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wr;
        logic [2:0]  aluOp;
        logic        aluSrcImm;
        logic        regWrite;
        logic        memRead;
        logic        memWrite;
        logic        memToReg;
        logic        branch;
        logic [31:0] pc4;
    } idex_t;

    idex_t       sbQ[$];
    idex_t       got;
    idex_t       want;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] model [0:31];
    logic [31:0] pc = 32'h0000_1000;

    function automatic idex_t sampleIdEx();
        idex_t s;
        s.regA = RegA_EX;          s.regB = RegB_EX;         s.imm = Imm_EX;
        s.rs = Rs_EX;              s.rt = Rt_EX;             s.wr = WriteReg_EX;
        s.aluOp = AluOp_EX;        s.aluSrcImm = AluSrcImm_EX;
        s.regWrite = RegWrite_EX;  s.memRead = MemRead_EX;   s.memWrite = MemWrite_EX;
        s.memToReg = MemToReg_EX;  s.branch = Branch_EX;     s.pc4 = PcPlus4_EX;
        return s;
    endfunction

    // Reference decode of an unsquashed, unstalled instruction against the shadow register file.
    function automatic idex_t refDecode(input logic [31:0] w, input logic [31:0] pc4);
        idex_t e;
        logic  ok;
        logic [5:0] op;
        logic [5:0] fn;
        e = '0;
        ok = 1'b1;
        op = w[31:26];
        fn = w[5:0];
        if (op == 6'h00 && w != 32'h0) begin
            e.regWrite = 1'b1;
            e.wr = w[15:11];
            if (fn == 6'h20) e.aluOp = 3'd0;
            else if (fn == 6'h22) e.aluOp = 3'd1;
            else if (fn == 6'h24) e.aluOp = 3'd2;
            else if (fn == 6'h25) e.aluOp = 3'd3;
            else if (fn == 6'h2a) e.aluOp = 3'd4;
            else ok = 1'b0;
        end else if (op == 6'h23) begin
            e.aluSrcImm = 1'b1; e.regWrite = 1'b1; e.memRead = 1'b1; e.memToReg = 1'b1;
            e.wr = w[20:16];
        end else if (op == 6'h2b) begin
            e.aluSrcImm = 1'b1; e.memWrite = 1'b1;
        end else if (op == 6'h04) begin
            e.aluOp = 3'd1; e.branch = 1'b1;
        end else if (op == 6'h08) begin
            e.aluSrcImm = 1'b1; e.regWrite = 1'b1; e.wr = w[20:16];
        end else begin
            ok = 1'b0;
        end
        if (!ok) return '0;
        e.regA = model[w[25:21]];
        e.regB = model[w[20:16]];
        e.imm  = {{16{w[15]}}, w[15:0]};
        e.rs   = w[25:21];
        e.rt   = w[20:16];
        e.pc4  = pc4;
        return e;
    endfunction

    // Drive one cycle of inputs at the falling edge and update the shadow register file.
    task automatic driveIn(input logic [31:0] w, input logic bt, input logic rst,
                           input logic wbEn, input logic [4:0] wbReg, input logic [31:0] wbData);
        @(negedge clk);
        pc = pc + 32'd4;
        FetchData_IF = w;
        PcPlus4_ID = pc;
        BranchTaken_EX = bt;
        reset = rst;
        RegWrite_WB = wbEn;
        WriteReg_WB = wbReg;
        WriteData_WB = wbData;
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (wbEn && wbReg != 5'd0) begin
            model[wbReg] = wbData;
        end
        #1;
    endtask

    task automatic test_reset();
        driveIn(32'h0, 1'b0, 1'b1, 1'b1, 5'd5, 32'hDEAD_BEEF);
        driveIn(32'h0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
        @(posedge clk); #1;
        checks++;
        if (sampleIdEx() !== idex_t'(0)) begin
            failures++; $display("FAIL reset_idex got=%h want=0", sampleIdEx());
        end
        checks++;
        if (IllegalSeen !== 1'b0) begin
            failures++; $display("FAIL reset_illegal got=%b want=0", IllegalSeen);
        end
        driveIn(32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        checks++;
        if (AnyStall !== 1'b0 || Jump_ID !== 1'b0) begin
            failures++; $display("FAIL reset_ctrl got stall=%b jump=%b want 0 0", AnyStall, Jump_ID);
        end
        sbQ.push_back(refDecode(32'h0, pc));
        @(posedge clk); #1;
        got = sampleIdEx(); want = sbQ.pop_front(); checks++;
        if (got !== want) begin
            failures++; $display("FAIL nop_idex got=%h want=%h", got, want);
        end
    endtask

    task automatic test_wb_bypass();
        logic [31:0] words [2];
        logic [4:0]  regs [2];
        logic [31:0] expA [2];
        words[0] = 32'h0108_1820; regs[0] = 5'd8; expA[0] = 32'h0000_1234;
        words[1] = 32'h0008_1820; regs[1] = 5'd0; expA[1] = 32'h0000_0000;
        for (int i = 0; i < 2; i++) begin
            driveIn(words[i], 1'b0, 1'b0, 1'b1, regs[i], (i == 0) ? 32'h0000_1234 : 32'h0000_FFFF);
            sbQ.push_back(refDecode(words[i], pc));
            @(posedge clk); #1;
            got = sampleIdEx(); want = sbQ.pop_front(); checks++;
            if (got !== want) begin
                failures++; $display("FAIL bypass_idex[%0d] got=%h want=%h", i, got, want);
            end
            checks++;
            if (RegA_EX !== expA[i] || RegB_EX !== 32'h0000_1234 || WriteReg_EX !== 5'd3 ||
                AluOp_EX !== 3'b000 || RegWrite_EX !== 1'b1) begin
                failures++;
                $display("FAIL bypass_fields[%0d] got a=%h b=%h wr=%0d op=%b rw=%b want a=%h b=00001234 wr=3 op=000 rw=1",
                         i, RegA_EX, RegB_EX, WriteReg_EX, AluOp_EX, RegWrite_EX, expA[i]);
            end
        end
    endtask

    task automatic test_load_use();
        logic [31:0] words [10];
        logic        stall [10];
        logic        wb    [10];
        words[0] = 32'h8C09_0004; stall[0] = 1'b0; wb[0] = 1'b0;  // lw $9,4($0)
        words[1] = 32'h0120_5020; stall[1] = 1'b1; wb[1] = 1'b1;  // add $10,$9,$0 (WB $9 meanwhile)
        words[2] = 32'h0120_5020; stall[2] = 1'b0; wb[2] = 1'b0;
        words[3] = 32'h8C00_0004; stall[3] = 1'b0; wb[3] = 1'b0;  // lw $0,4($0)
        words[4] = 32'h0000_5020; stall[4] = 1'b0; wb[4] = 1'b0;  // add $10,$0,$0
        words[5] = 32'h8C09_0004; stall[5] = 1'b0; wb[5] = 1'b0;
        words[6] = 32'hAC09_0000; stall[6] = 1'b1; wb[6] = 1'b0;  // sw $9 reads rt
        words[7] = 32'hAC09_0000; stall[7] = 1'b0; wb[7] = 1'b0;
        words[8] = 32'h8C09_0004; stall[8] = 1'b0; wb[8] = 1'b0;
        words[9] = 32'h2009_0001; stall[9] = 1'b0; wb[9] = 1'b0;  // addi $9,$0,1 reads rs only
        for (int i = 0; i < 10; i++) begin
            driveIn(words[i], 1'b0, 1'b0, wb[i], 5'd9, 32'h0000_BEEF);
            checks++;
            if (AnyStall !== stall[i]) begin
                failures++; $display("FAIL loaduse_stall[%0d] got=%b want=%b", i, AnyStall, stall[i]);
            end
            sbQ.push_back(stall[i] ? idex_t'(0) : refDecode(words[i], pc));
            @(posedge clk); #1;
            got = sampleIdEx(); want = sbQ.pop_front(); checks++;
            if (got !== want) begin
                failures++; $display("FAIL loaduse_idex[%0d] got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_jump();
        driveIn(32'h0800_0010, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
        checks++;
        if (Jump_ID !== 1'b1 || JumpTgt_ID !== 26'h000_0010 || AnyStall !== 1'b0) begin
            failures++;
            $display("FAIL jump_ctrl got j=%b tgt=%h stall=%b want 1 0000010 0", Jump_ID, JumpTgt_ID, AnyStall);
        end
        sbQ.push_back(idex_t'(0));
        @(posedge clk); #1;
        got = sampleIdEx(); want = sbQ.pop_front(); checks++;
        if (got !== want) begin
            failures++; $display("FAIL jump_idex got=%h want=%h", got, want);
        end
    endtask

    task automatic test_squash();
        logic [31:0] words [6];
        logic        bt  [6];
        logic        rst [6];
        words[0] = 32'h0800_0010; bt[0] = 1'b1; rst[0] = 1'b0;
        words[1] = 32'h8C09_0004; bt[1] = 1'b0; rst[1] = 1'b0;
        words[2] = 32'h0120_5020; bt[2] = 1'b1; rst[2] = 1'b0;
        words[3] = 32'h8C09_0004; bt[3] = 1'b0; rst[3] = 1'b0;
        words[4] = 32'h0120_5020; bt[4] = 1'b0; rst[4] = 1'b1;
        words[5] = 32'h0800_0010; bt[5] = 1'b1; rst[5] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            driveIn(words[i], bt[i], rst[i], 1'b0, 5'd0, 32'h0);
            checks++;
            if (Jump_ID !== 1'b0 || AnyStall !== 1'b0) begin
                failures++; $display("FAIL squash_ctrl[%0d] got j=%b stall=%b want 0 0", i, Jump_ID, AnyStall);
            end
            sbQ.push_back((bt[i] || rst[i]) ? idex_t'(0) : refDecode(words[i], pc));
            @(posedge clk); #1;
            got = sampleIdEx(); want = sbQ.pop_front(); checks++;
            if (got !== want) begin
                failures++; $display("FAIL squash_idex[%0d] got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_illegal();
        logic [31:0] words [8];
        logic        bt  [8];
        logic        rst [8];
        logic        ill [8];
        words[0] = 32'hFC00_0000; bt[0] = 1'b1; rst[0] = 1'b0; ill[0] = 1'b0;
        words[1] = 32'hFC00_0000; bt[1] = 1'b0; rst[1] = 1'b0; ill[1] = 1'b1;
        words[2] = 32'h0000_0000; bt[2] = 1'b0; rst[2] = 1'b0; ill[2] = 1'b1;
        words[3] = 32'h0108_1820; bt[3] = 1'b0; rst[3] = 1'b0; ill[3] = 1'b1;
        words[4] = 32'h0000_0000; bt[4] = 1'b0; rst[4] = 1'b1; ill[4] = 1'b0;
        words[5] = 32'h0000_0000; bt[5] = 1'b0; rst[5] = 1'b0; ill[5] = 1'b0;
        words[6] = 32'h0000_000C; bt[6] = 1'b0; rst[6] = 1'b0; ill[6] = 1'b1;
        words[7] = 32'h0000_0000; bt[7] = 1'b0; rst[7] = 1'b1; ill[7] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            driveIn(words[i], bt[i], rst[i], 1'b0, 5'd0, 32'h0);
            sbQ.push_back((bt[i] || rst[i]) ? idex_t'(0) : refDecode(words[i], pc));
            @(posedge clk); #1;
            got = sampleIdEx(); want = sbQ.pop_front(); checks++;
            if (got !== want) begin
                failures++; $display("FAIL illegal_idex[%0d] got=%h want=%h", i, got, want);
            end
            checks++;
            if (IllegalSeen !== ill[i]) begin
                failures++; $display("FAIL illegal_flag[%0d] got=%b want=%b", i, IllegalSeen, ill[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0]  fns [5];
        logic [31:0] w;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        int          kind;
        fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h25; fns[4] = 6'h2a;
        for (int i = 0; i < 60; i++) begin
            rs = 5'($urandom_range(0, 31));
            rt = 5'($urandom_range(0, 31));
            rd = 5'($urandom_range(0, 31));
            imm = 16'($urandom);
            kind = $urandom_range(0, 7);
            if (kind < 5)       w = {6'h00, rs, rt, rd, 5'd0, fns[kind]};
            else if (kind == 5) w = {6'h2b, rs, rt, imm};
            else if (kind == 6) w = {6'h04, rs, rt, imm};
            else                w = {6'h08, rs, rt, imm};
            driveIn(w, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
            checks++;
            if (AnyStall !== 1'b0 || Jump_ID !== 1'b0) begin
                failures++; $display("FAIL b2b_ctrl[%0d] got stall=%b j=%b want 0 0", i, AnyStall, Jump_ID);
            end
            sbQ.push_back(refDecode(w, pc));
            @(posedge clk); #1;
            got = sampleIdEx(); want = sbQ.pop_front(); checks++;
            if (got !== want) begin
                failures++; $display("FAIL b2b_idex[%0d] w=%h got=%h want=%h", i, w, got, want);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        test_reset();
        test_wb_bypass();
        test_load_use();
        test_jump();
        test_squash();
        test_illegal();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
